rf_writeback: RTL

- Write-side front end of the 16x16 register file.
- Merges results from the single-cycle ALU path and the variable-latency load path into the one register-file write port (Rd / writeData / we).
- Buffers load returns in a small FIFO and keeps a per-register pending-load scoreboard for the issue stage.
- Runs a halt drain: on hlt, all outstanding loads are retired before drained is reported.

---
 rtl/rf_pkg.sv | 27 ++
 rtl/wb_fifo.sv | 81 ++++++++
 rtl/rf_writeback.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared widths, the write-back entry type and the drain-FSM
//               state encoding for the register-file write-side front end.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int DATA_W   = 16;   // register data width
    localparam int REG_AW   = 4;    // register index width
    localparam int NUM_REGS = 16;   // number of architectural registers

    // One pending register-file write: destination index and data.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } wb_state_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO of wb_entry_t used to buffer load returns.
//               Show-ahead: head always presents the oldest entry.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               push, din  - enqueue request and entry (ignored when full)
//               pop        - dequeue request (ignored when empty)
//               full/empty - occupancy flags
//               count      - number of stored entries (0..QDEPTH)
//               head       - oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import rf_pkg::*;
#(
    parameter  int QDEPTH = 4,                  // power of 2, at least 2
    localparam int PTR_W  = $clog2(QDEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output wb_entry_t        head
);

    wb_entry_t        mem_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (count_q == CNT_W'(QDEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped, even if a pop frees a slot in the
    // same cycle; the producer has already seen the FIFO as full.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers wrap naturally because QDEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/rf_writeback.sv
`default_nettype none
// ============================================================================
// Module      : rf_writeback
// Description : Write-side front end of the 16x16 register file. Merges the
//               single-cycle ALU path and the buffered load-return path onto
//               one registered write port, tracks outstanding loads per
//               register, and runs a halt drain.
// Ports       : clk, rst                    - clock, sync active-high reset
//               aluValid/aluRd/aluData      - ALU result (never stalled)
//               ldIssue/ldIssueRd           - load issued, marks rd pending
//               ldValid/ldRd/ldData/ldReady - load return handshake
//               Rd/writeData/we             - registered RF write port
//               busy                        - per-register load-pending flags
//               hlt/drained                 - halt request / drain complete
// Revision    : 1.0 - initial release
// ============================================================================
module rf_writeback
    import rf_pkg::*;
#(
    parameter  int QDEPTH = 4,                  // power of 2, at least 2
    localparam int CNT_W  = $clog2(QDEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                aluValid,
    input  logic [REG_AW-1:0]   aluRd,
    input  logic [DATA_W-1:0]   aluData,
    input  logic                ldIssue,
    input  logic [REG_AW-1:0]   ldIssueRd,
    input  logic                ldValid,
    input  logic [REG_AW-1:0]   ldRd,
    input  logic [DATA_W-1:0]   ldData,
    output logic                ldReady,
    output logic [REG_AW-1:0]   Rd,
    output logic [DATA_W-1:0]   writeData,
    output logic                we,
    output logic [NUM_REGS-1:0] busy,
    input  logic                hlt,
    output logic                drained
);

    wb_state_t          state_q, state_d;
    logic [REG_AW-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               we_q, we_d;

    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    wb_entry_t          w_head;
    wb_entry_t          w_ld_entry;
    logic               w_push;
    logic               w_pop;
    logic               w_alu_sel;
    logic               w_inc_en;
    logic               w_dec_en;

    assign ldReady    = !w_full && (state_q != HALTED);
    assign w_push     = ldValid && ldReady;
    assign w_ld_entry = '{rd: ldRd, data: ldData};

    // ALU results are only honoured while running; during a drain the issue
    // side is frozen. The FIFO head takes the port whenever the ALU does not.
    assign w_alu_sel  = aluValid && (state_q == RUN);
    assign w_pop      = !w_empty && !w_alu_sel && (state_q != HALTED);

    // Register 0 is never tracked, so its counter stays at zero.
    assign w_inc_en   = ldIssue && (state_q == RUN) && (ldIssueRd != '0);
    assign w_dec_en   = w_pop && (w_head.rd != '0);

    wb_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_ld_entry),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count),
        .head  (w_head)
    );

    // ---------------- write-port arbitration --------------------------------
    // A selected entry targeting r0 is consumed without raising we.
    always_comb begin
        rd_d    = rd_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        if (w_alu_sel) begin
            rd_d    = aluRd;
            wdata_d = aluData;
            we_d    = (aluRd != '0);
        end else if (w_pop) begin
            rd_d    = w_head.rd;
            wdata_d = w_head.data;
            we_d    = (w_head.rd != '0);
        end
    end

    // ---------------- drain state machine -----------------------------------
    // HALTED waits for the last write to leave the output register so that
    // drained never precedes the final register-file update.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (hlt) state_d = DRAIN;
            DRAIN:   if ((w_count == '0) && (busy == '0) && !we_q)
                         state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            rd_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign Rd        = rd_q;
    assign writeData = wdata_q;
    assign we        = we_q;
    assign drained   = (state_q == HALTED);

    // ---------------- pending-load scoreboard -------------------------------
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_sb
        logic [1:0] cnt_q, cnt_d;
        logic       w_inc;
        logic       w_dec;

        assign w_inc = w_inc_en && (ldIssueRd == REG_AW'(i));
        assign w_dec = w_dec_en && (w_head.rd == REG_AW'(i));

        // Counter saturates at both ends; simultaneous inc/dec cancels.
        always_comb begin
            cnt_d = cnt_q;
            if (w_inc && !w_dec && (cnt_q != 2'd3))
                cnt_d = cnt_q + 2'd1;
            else if (w_dec && !w_inc && (cnt_q != 2'd0))
                cnt_d = cnt_q - 2'd1;
        end

        always_ff @(posedge clk) begin
            if (rst) cnt_q <= 2'd0;
            else     cnt_q <= cnt_d;
        end

        assign busy[i] = (cnt_q != 2'd0);

        a_sb_overflow: assert property (@(posedge clk) disable iff (rst)
            !(w_inc && !w_dec && (cnt_q == 2'd3)));
        a_sb_underflow: assert property (@(posedge clk) disable iff (rst)
            !(w_dec && !w_inc && (cnt_q == 2'd0)));
    end

    // A load return offered while not ready is dropped.
    a_ld_protocol: assert property (@(posedge clk) disable iff (rst)
        !(ldValid && !ldReady));

endmodule : rf_writeback
`default_nettype wire
